cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter that shares the single common-data-bus writeback slot between the execution-side result producers (ALU, load unit, branch unit). Each producer deposits one result into a private one-entry holding buffer. The arbiter grants one buffered result per cycle onto a registered writeback bus toward the ROB. A pipeline flush discards everything in flight.

## Interface
Parameters:
- NUM_SRC, 3, number of producers; index 0 = ALU, 1 = load, 2 = branch
- TAG_W, 4, ROB rename tag width
- DATA_W, 32, result width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- rdy  in  1  global enable; when 0, all state holds
- flush  in  1  misprediction flush; discards buffers and the writeback register
- src_valid  in  NUM_SRC  producer i offers a result
- src_rename  in  NUM_SRC*TAG_W  packed ROB tags; slice i = [i*TAG_W +: TAG_W]
- src_value  in  NUM_SRC*DATA_W  packed result values; slice i = [i*DATA_W +: DATA_W]
- src_ready  out  NUM_SRC  buffer i empty; registered-derived, no combinational path from inputs
- wb_valid  out  1  writeback result valid this cycle
- wb_rename  out  TAG_W  ROB tag of the result
- wb_value  out  DATA_W  result value
- wb_src  out  clog2(NUM_SRC)  index of the granted producer

## Operation
- State per source i:
  - buf_valid[i]
  - buf_rename[i]
  - buf_value[i]
- Global state:
  - rr_ptr, width clog2(NUM_SRC)
  - wb_* registers
- src_ready[i] = !buf_valid[i].
- Accept: a source is accepted when src_valid[i] && src_ready[i] && rdy && !flush. At the edge, the buffer loads src_rename/src_value and buf_valid[i] sets.
- Arbitration, evaluated each cycle over buf_valid:
  - Search for the first set bit, starting at rr_ptr and wrapping modulo NUM_SRC.
  - Winner g: at the edge, wb_valid←1, wb_rename/wb_value←buf[g], wb_src←g, buf_valid[g]←0, rr_ptr←(g+1) mod NUM_SRC.
  - No valid buffer: wb_valid←0 and rr_ptr holds.
- A buffer being granted this cycle is not refilled in the same cycle, because src_ready was 0. Sustained throughput per source is therefore one result every 2 cycles; aggregate throughput is 1 per cycle.
- Flush (rdy=1):
  - At the edge, all buf_valid←0 and wb_valid←0.
  - Same-cycle accepts are dropped.
  - rr_ptr is preserved.
  - Flush has priority over both accept and grant.
- rdy=0: no accept, no grant, and wb_* holds its value. wb_valid stays at its prior value, so the ROB must also qualify by rdy.
- Width rules: rr_ptr increments with explicit wrap at NUM_SRC-1→0, not natural overflow, because NUM_SRC need not be a power of 2.

## Timing
- Reset values:
  - buf_valid=0, so src_ready=all-ones
  - rr_ptr=0
  - wb_valid=0, wb_rename=0, wb_value=0, wb_src=0
- Reset is asynchronous. Asserting it mid-operation clears everything immediately, with no pending grant completed.
- Latency: a result accepted at edge E appears on wb_* after edge E+1 if uncontended. With all sources contending, the worst case is edge E+NUM_SRC.
- wb_valid is a 1-cycle pulse per result. There is no backpressure from the ROB; the ROB always consumes.
- Accept and grant of different sources may coincide in one cycle.

## Structure
- Shared package or header holds:
  - TAG_W and DATA_W constants
  - source index constants SRC_ALU=0, SRC_LD=1, SRC_BR=2
- One sub-module, rr_arbiter:
  - inputs: req vector and ptr
  - outputs: one-hot grant, encoded index, any_grant
  - purely combinational
- The top holds the buffers, rr_ptr and the wb registers.

## Test plan
- Reset/idle: hold rst=0, then release. Required: src_ready=3'b111, wb_valid=0. A single ALU offer (tag 5, value 0x1234) at edge 1 gives wb_valid=1, wb_rename=5, wb_value=0x1234, wb_src=0 after edge 2, and src_ready[0] back to 1 after edge 2.
- Contention fairness: all three sources offer (tags 1, 2, 3) at the same edge with rr_ptr=0. Required: writebacks in order tags 1, 2, 3 on consecutive cycles, and rr_ptr=0 afterward.
- Rotation: with rr_ptr=2, sources 0 and 2 are buffered. Required: source 2 is granted first, then source 0, and rr_ptr ends at 1.
- Flush: flush with two buffered results and wb_valid=1, while source 1 offers in the same cycle. Required: after the edge, all buffers are empty, wb_valid=0, the offer is dropped, and no writeback occurs in later cycles.
- rdy stall: hold rdy=0 for 3 cycles with buffered results and wb_valid=1. Required: wb_* and buffers are unchanged and no accept occurs; grants resume on the first cycle rdy=1.
- Async reset mid-operation: assert rst between edges with buffers full. Required: outputs clear immediately without waiting for a clock edge, and src_ready=all-ones.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus writeback arbiter: widths and
// producer index assignments.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_SRC = 3;
  localparam int CDB_TAG_W   = 4;
  localparam int CDB_DATA_W  = 32;

  localparam int SRC_ALU = 0;
  localparam int SRC_LD  = 1;
  localparam int SRC_BR  = 2;

  // Index width that stays at least one bit wide for a single-source build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_SRC.
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = CDB_NUM_SRC
) (
  input  logic [NUM_SRC-1:0]          req,
  input  logic [idx_w(NUM_SRC)-1:0]   ptr,
  output logic [NUM_SRC-1:0]          gnt,
  output logic [idx_w(NUM_SRC)-1:0]   gnt_idx,
  output logic                        any_gnt
);

  localparam int IDX_W = idx_w(NUM_SRC);

  always_comb begin
    logic [IDX_W:0] cand;
    cand    = '0;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      // ptr and k are both below NUM_SRC, so one subtraction is a full wrap.
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_SRC)) begin
        cand = cand - (IDX_W+1)'(NUM_SRC);
      end
      if (!any_gnt && req[cand[IDX_W-1:0]]) begin
        any_gnt = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
    gnt[gnt_idx] = any_gnt;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the single CDB writeback slot between producers, each with a
// one-entry holding buffer, granting one buffered result per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = CDB_NUM_SRC,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]    src_rename,
  input  logic [NUM_SRC*DATA_W-1:0]   src_value,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic                        wb_valid,
  output logic [TAG_W-1:0]            wb_rename,
  output logic [DATA_W-1:0]           wb_value,
  output logic [idx_w(NUM_SRC)-1:0]   wb_src
);

  localparam int IDX_W = idx_w(NUM_SRC);

  logic [TAG_W-1:0]  src_rename_a [NUM_SRC];
  logic [DATA_W-1:0] src_value_a  [NUM_SRC];

  logic [NUM_SRC-1:0] buf_valid_q, buf_valid_d;
  logic [TAG_W-1:0]   buf_rename_q [NUM_SRC];
  logic [TAG_W-1:0]   buf_rename_d [NUM_SRC];
  logic [DATA_W-1:0]  buf_value_q  [NUM_SRC];
  logic [DATA_W-1:0]  buf_value_d  [NUM_SRC];
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0]   wb_rename_q, wb_rename_d;
  logic [DATA_W-1:0]  wb_value_q, wb_value_d;
  logic [IDX_W-1:0]   wb_src_q, wb_src_d;

  logic [NUM_SRC-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               any_gnt;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign src_rename_a[gi] = src_rename[gi*TAG_W +: TAG_W];
    assign src_value_a[gi]  = src_value[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
    .req     (buf_valid_q),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  always_comb begin
    buf_valid_d  = buf_valid_q;
    buf_rename_d = buf_rename_q;
    buf_value_d  = buf_value_q;
    rr_ptr_d     = rr_ptr_q;
    wb_valid_d   = wb_valid_q;
    wb_rename_d  = wb_rename_q;
    wb_value_d   = wb_value_q;
    wb_src_d     = wb_src_q;
    if (rdy) begin
      if (flush) begin
        buf_valid_d = '0;
        wb_valid_d  = 1'b0;
      end else begin
        wb_valid_d  = any_gnt;
        buf_valid_d = buf_valid_q & ~gnt;
        if (any_gnt) begin
          wb_rename_d = buf_rename_q[gnt_idx];
          wb_value_d  = buf_value_q[gnt_idx];
          wb_src_d    = gnt_idx;
          rr_ptr_d    = (gnt_idx == IDX_W'(NUM_SRC-1)) ? '0 : gnt_idx + IDX_W'(1);
        end
        // Only empty buffers accept, so an accept never collides with a grant.
        for (int i = 0; i < NUM_SRC; i++) begin
          if (src_valid[i] && !buf_valid_q[i]) begin
            buf_valid_d[i]  = 1'b1;
            buf_rename_d[i] = src_rename_a[i];
            buf_value_d[i]  = src_value_a[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        buf_rename_q[i] <= '0;
        buf_value_q[i]  <= '0;
      end
      rr_ptr_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_rename_q <= '0;
      wb_value_q  <= '0;
      wb_src_q    <= '0;
    end else begin
      buf_valid_q  <= buf_valid_d;
      buf_rename_q <= buf_rename_d;
      buf_value_q  <= buf_value_d;
      rr_ptr_q     <= rr_ptr_d;
      wb_valid_q   <= wb_valid_d;
      wb_rename_q  <= wb_rename_d;
      wb_value_q   <= wb_value_d;
      wb_src_q     <= wb_src_d;
    end
  end

  assign src_ready = ~buf_valid_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rename = wb_rename_q;
  assign wb_value  = wb_value_q;
  assign wb_src    = wb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scenarios plus a randomized run of cdb_arbiter against a
// behavioural model of buffers, round-robin order and flush/stall rules.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int TW = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            rdy = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    src_valid = '0;
  logic [N*TW-1:0] src_rename = '0;
  logic [N*DW-1:0] src_value = '0;
  logic [N-1:0]    src_ready;
  logic            wb_valid;
  logic [TW-1:0]   wb_rename;
  logic [DW-1:0]   wb_value;
  logic [1:0]      wb_src;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: what each producer's buffer holds, whose turn it is, and
  // what the bus currently shows.
  bit            m_full [N];
  logic [TW-1:0] m_tag  [N];
  logic [DW-1:0] m_val  [N];
  int            m_turn;
  bit            m_wbv;
  logic [TW-1:0] m_wbt;
  logic [DW-1:0] m_wbd;
  int            m_wbs;

  cdb_arbiter #(.NUM_SRC(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .src_valid  (src_valid),
    .src_rename (src_rename),
    .src_value  (src_value),
    .src_ready  (src_ready),
    .wb_valid   (wb_valid),
    .wb_rename  (wb_rename),
    .wb_value   (wb_value),
    .wb_src     (wb_src)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_tag[i] = '0; m_val[i] = '0;
    end
    m_turn = 0; m_wbv = 0; m_wbt = '0; m_wbd = '0; m_wbs = 0;
  endtask

  // Advance the model by one cycle from the current inputs, then clock the DUT.
  task automatic tick();
    bit was_full [N];
    int g;
    for (int i = 0; i < N; i++) was_full[i] = m_full[i];
    if (rdy && flush) begin
      for (int i = 0; i < N; i++) m_full[i] = 0;
      m_wbv = 0;
    end else if (rdy) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && was_full[(m_turn + k) % N]) g = (m_turn + k) % N;
      if (g >= 0) begin
        m_wbv = 1; m_wbt = m_tag[g]; m_wbd = m_val[g]; m_wbs = g;
        m_full[g] = 0;
        m_turn = (g + 1) % N;
      end else begin
        m_wbv = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (src_valid[i] && !was_full[i]) begin
          m_full[i] = 1;
          m_tag[i]  = src_rename[i*TW +: TW];
          m_val[i]  = src_value[i*DW +: DW];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int i, input logic [TW-1:0] tag, input logic [DW-1:0] val);
    src_valid[i]            = 1'b1;
    src_rename[i*TW +: TW]  = tag;
    src_value[i*DW +: DW]   = val;
  endtask

  task automatic clear_inputs();
    src_valid = '0;
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if (src_ready !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %b expected 111", src_ready); end
    n_tests++;
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
    n_tests++;
    if (wb_rename !== '0 || wb_value !== '0 || wb_src !== '0) begin
      n_fail++; $display("FAIL reset_wb_fields: got tag %0h val %0h src %0d expected 0", wb_rename, wb_value, wb_src);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    $display("[TB] reset released");
  endtask

  task automatic test_single();
    offer(SRC_ALU, 4'd5, 32'h1234);
    tick();
    n_tests++;
    if (src_ready !== 3'b110 || wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_accept: got ready %b wb_valid %b expected 110 0", src_ready, wb_valid);
    end
    clear_inputs();
    tick();
    $display("[TB] single wb: valid %b tag %0d value %0h src %0d", wb_valid, wb_rename, wb_value, wb_src);
    n_tests++;
    if (wb_valid !== 1'b1 || wb_rename !== 4'd5 || wb_value !== 32'h1234 || wb_src !== 2'd0) begin
      n_fail++; $display("FAIL single_wb: got %b/%0d/%0h/%0d expected 1/5/1234/0", wb_valid, wb_rename, wb_value, wb_src);
    end
    n_tests++;
    if (src_ready !== 3'b111) begin n_fail++; $display("FAIL single_ready_back: got %b expected 111", src_ready); end
    tick();
    n_tests++;
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b expected 0", wb_valid); end
  endtask

  task automatic test_contention();
    // Grant the branch unit alone so the turn wraps back to the ALU.
    offer(SRC_BR, 4'd15, 32'hF);
    tick(); clear_inputs(); tick(); tick();
    offer(0, 4'd1, 32'd100); offer(1, 4'd2, 32'd200); offer(2, 4'd3, 32'd300);
    tick(); clear_inputs();
    for (int k = 1; k <= 3; k++) begin
      tick();
      $display("[TB] contention wb: tag %0d src %0d", wb_rename, wb_src);
      n_tests++;
      if (wb_valid !== 1'b1 || wb_rename !== TW'(k) || wb_value !== DW'(k*100) || wb_src !== 2'(k-1)) begin
        n_fail++; $display("FAIL contention_order%0d: got %b/%0d/%0d expected 1/%0d/%0d", k, wb_valid, wb_rename, wb_src, k, k-1);
      end
    end
    tick();
    // Turn is back at the ALU: it must beat the branch unit.
    offer(0, 4'd7, 32'd7); offer(2, 4'd8, 32'd8);
    tick(); clear_inputs(); tick();
    n_tests++;
    if (wb_valid !== 1'b1 || wb_src !== 2'd0 || wb_rename !== 4'd7) begin
      n_fail++; $display("FAIL contention_ptr_zero: got src %0d tag %0d expected 0 7", wb_src, wb_rename);
    end
    tick();
    n_tests++;
    if (wb_valid !== 1'b1 || wb_src !== 2'd2 || wb_rename !== 4'd8) begin
      n_fail++; $display("FAIL contention_second: got src %0d tag %0d expected 2 8", wb_src, wb_rename);
    end
    tick();
  endtask

  task automatic test_rotation();
    offer(SRC_LD, 4'd4, 32'h44);
    tick(); clear_inputs(); tick(); tick();
    offer(0, 4'hA, 32'hAA); offer(2, 4'hB, 32'hBB);
    tick(); clear_inputs(); tick();
    $display("[TB] rotation wb: tag %0h src %0d", wb_rename, wb_src);
    n_tests++;
    if (wb_valid !== 1'b1 || wb_src !== 2'd2 || wb_value !== 32'hBB) begin
      n_fail++; $display("FAIL rotation_first: got src %0d value %0h expected 2 bb", wb_src, wb_value);
    end
    tick();
    $display("[TB] rotation wb: tag %0h src %0d", wb_rename, wb_src);
    n_tests++;
    if (wb_valid !== 1'b1 || wb_src !== 2'd0 || wb_value !== 32'hAA) begin
      n_fail++; $display("FAIL rotation_second: got src %0d value %0h expected 0 aa", wb_src, wb_value);
    end
    tick();
    // Turn should now sit at the load unit.
    offer(0, 4'hC, 32'hCC); offer(1, 4'hD, 32'hDD);
    tick(); clear_inputs(); tick();
    n_tests++;
    if (wb_valid !== 1'b1 || wb_src !== 2'd1 || wb_rename !== 4'hD) begin
      n_fail++; $display("FAIL rotation_ptr_one: got src %0d tag %0h expected 1 d", wb_src, wb_rename);
    end
    tick(); tick();
  endtask

  task automatic test_flush();
    offer(0, 4'd1, 32'h11); offer(1, 4'd2, 32'h22); offer(2, 4'd3, 32'h33);
    tick(); clear_inputs(); tick();
    n_tests++;
    if (wb_valid !== 1'b1 || wb_src !== 2'd1 || src_ready !== 3'b010) begin
      n_fail++; $display("FAIL flush_setup: got wb %b src %0d ready %b expected 1 1 010", wb_valid, wb_src, src_ready);
    end
    flush = 1'b1;
    offer(1, 4'd9, 32'h99);
    tick();
    flush = 1'b0; clear_inputs();
    $display("[TB] flush: ready %b wb_valid %b", src_ready, wb_valid);
    n_tests++;
    if (src_ready !== 3'b111 || wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear: got ready %b wb_valid %b expected 111 0", src_ready, wb_valid);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_wb%0d: got %b expected 0", c, wb_valid); end
    end
  endtask

  task automatic test_stall();
    offer(0, 4'd5, 32'h55); offer(2, 4'd6, 32'h66);
    tick(); clear_inputs(); tick();
    n_tests++;
    if (wb_valid !== 1'b1 || wb_src !== 2'd2 || wb_rename !== 4'd6) begin
      n_fail++; $display("FAIL stall_setup: got %b src %0d tag %0d expected 1 2 6", wb_valid, wb_src, wb_rename);
    end
    rdy = 1'b0;
    offer(1, 4'd14, 32'hE1); offer(2, 4'd13, 32'hE2);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (wb_valid !== 1'b1 || wb_src !== 2'd2 || wb_rename !== 4'd6 || wb_value !== 32'h66 || src_ready !== 3'b110) begin
        n_fail++; $display("FAIL stall_hold%0d: got %b/%0d/%0d/%0h ready %b expected 1/2/6/66 110", c, wb_valid, wb_src, wb_rename, wb_value, src_ready);
      end
    end
    rdy = 1'b1; clear_inputs();
    tick();
    $display("[TB] stall resume wb: tag %0d src %0d", wb_rename, wb_src);
    n_tests++;
    if (wb_valid !== 1'b1 || wb_src !== 2'd0 || wb_rename !== 4'd5 || src_ready !== 3'b111) begin
      n_fail++; $display("FAIL stall_resume: got %b src %0d tag %0d ready %b expected 1 0 5 111", wb_valid, wb_src, wb_rename, src_ready);
    end
    tick();
  endtask

  task automatic test_async_reset();
    offer(0, 4'd1, 32'h1); offer(1, 4'd2, 32'h2); offer(2, 4'd3, 32'h3);
    tick(); clear_inputs(); tick();
    n_tests++;
    if (wb_valid !== 1'b1 || src_ready === 3'b111) begin
      n_fail++; $display("FAIL async_setup: got wb %b ready %b expected 1 not-111", wb_valid, src_ready);
    end
    #2 rst = 1'b0;
    #1;
    $display("[TB] async reset: ready %b wb_valid %b", src_ready, wb_valid);
    n_tests++;
    if (src_ready !== 3'b111 || wb_valid !== 1'b0 || wb_rename !== '0 || wb_value !== '0 || wb_src !== '0) begin
      n_fail++; $display("FAIL async_clear: got ready %b wb %b tag %0h val %0h src %0d expected 111 0 0 0 0", src_ready, wb_valid, wb_rename, wb_value, wb_src);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [N-1:0] exp_ready;
    for (int c = 0; c < 400; c++) begin
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++) begin
        src_valid[i]           = $urandom_range(0, 1) == 1;
        src_rename[i*TW +: TW] = TW'($urandom);
        src_value[i*DW +: DW]  = $urandom;
      end
      tick();
      for (int i = 0; i < N; i++) exp_ready[i] = !m_full[i];
      if (wb_valid && rdy) $display("[TB] rand wb: src %0d tag %0h value %08h", wb_src, wb_rename, wb_value);
      n_tests++;
      if (src_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready@%0d: got %b expected %b", c, src_ready, exp_ready);
      end
      n_tests++;
      if (wb_valid !== m_wbv || wb_rename !== m_wbt || wb_value !== m_wbd || wb_src !== 2'(m_wbs)) begin
        n_fail++; $display("FAIL rand_wb@%0d: got %b/%0h/%0h/%0d expected %b/%0h/%0h/%0d", c, wb_valid, wb_rename, wb_value, wb_src, m_wbv, m_wbt, m_wbd, m_wbs);
      end
    end
    rdy = 1'b1; flush = 1'b0; clear_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_flush();
    test_stall();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
